// File: rtl/pwm_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : pwm_pkg
// Description : Shared types, widths and the ramp-step helper for the
//               PWM soft-start controller.
// Revision    : 1.0 - initial release
// ============================================================================
package pwm_pkg;

    localparam int DUTY_W     = 5;
    localparam int PERIOD_LEN = 32;
    localparam int PCNT_W     = $clog2(PERIOD_LEN);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARMED = 3'd1,
        ST_RAMP  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_STOP  = 3'd4
    } state_t;

    // Move cur toward tgt by at most step, never past tgt. Done one bit wider
    // than the duty code so the intermediate sum cannot wrap.
    function automatic logic [DUTY_W-1:0] ramp_next(
        input logic [DUTY_W-1:0] cur,
        input logic [DUTY_W-1:0] tgt,
        input logic [DUTY_W:0]   step
    );
        logic [DUTY_W:0] w_c;
        logic [DUTY_W:0] w_t;
        logic [DUTY_W:0] w_dist;
        logic [DUTY_W:0] w_delta;
        w_c     = {1'b0, cur};
        w_t     = {1'b0, tgt};
        w_dist  = (w_t >= w_c) ? (w_t - w_c) : (w_c - w_t);
        w_delta = (w_dist < step) ? w_dist : step;
        if (w_t >= w_c) begin
            return DUTY_W'(w_c + w_delta);
        end
        return DUTY_W'(w_c - w_delta);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_period_timer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : pwm_period_timer
// Description : Free-running PWM period counter; flags the last cycle of
//               every period.
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_period_timer
    import pwm_pkg::*;
(
    input  logic clk,
    input  logic rst,
    output logic o_period_tick
);

    localparam logic [PCNT_W-1:0] c_LAST = PCNT_W'(PERIOD_LEN - 1);

    logic [PCNT_W-1:0] r_count;

    // Count 0..PERIOD_LEN-1 and wrap; held at 0 while reset is asserted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (r_count == c_LAST) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_period_tick = (r_count == c_LAST);

endmodule
`default_nettype wire

// File: rtl/pwm_ramp_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : pwm_ramp_ctrl
// Description : Soft-start / soft-stop controller for a downstream PWM stage.
//               Duty code and enable only change on period boundaries; the
//               code walks toward the target by at most STEP every RAMP_DIV
//               periods.
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_ramp_ctrl
    import pwm_pkg::*;
#(
    parameter int RAMP_DIV = 4,
    parameter int STEP     = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              set_valid,
    input  logic [DUTY_W-1:0] set_duty,
    output logic              set_ready,
    output logic [DUTY_W-1:0] control,
    output logic              enable,
    output logic              period_tick,
    output logic              at_target
);

    localparam logic [7:0]      c_DIV_LAST = 8'(RAMP_DIV - 1);
    localparam logic [DUTY_W:0] c_STEP     = (DUTY_W + 1)'(STEP);

    state_t            r_state;
    logic [DUTY_W-1:0] r_target;
    logic [DUTY_W-1:0] r_control;
    logic              r_enable;
    logic [7:0]        r_div;

    logic              w_tick;
    logic              w_accept;
    logic              w_div_done;
    logic              w_ramping;
    logic [DUTY_W-1:0] w_stepped;

    pwm_period_timer u_timer (
        .clk           (clk),
        .rst           (rst),
        .o_period_tick (w_tick)
    );

    assign w_accept   = set_valid & set_ready;
    assign w_div_done = (r_div == c_DIV_LAST);
    assign w_ramping  = (r_state == ST_RAMP) || (r_state == ST_STOP);
    assign w_stepped  = ramp_next(r_control, r_target, c_STEP);

    // Main controller: state, target, divider, duty code and enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_target  <= '0;
            r_control <= '0;
            r_enable  <= 1'b0;
            r_div     <= '0;
        end else begin
            // A setpoint taken alongside stop still handshakes but is dropped.
            if (w_accept) begin
                r_target <= stop ? '0 : set_duty;
            end
            if (stop && ((r_state == ST_RAMP) || (r_state == ST_HOLD))) begin
                r_target <= '0;
            end

            // Divider counts period ticks; a full count applies one step.
            if (w_ramping && w_tick) begin
                if (w_div_done) begin
                    r_control <= w_stepped;
                    r_div     <= '0;
                end else begin
                    r_div <= r_div + 1'b1;
                end
            end

            case (r_state)
                ST_IDLE: begin
                    if (start && !stop) begin
                        r_state <= ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (stop) begin
                        r_state <= ST_IDLE;
                    end else if (w_tick) begin
                        r_state  <= ST_RAMP;
                        r_enable <= 1'b1;
                        r_div    <= '0;
                    end
                end
                ST_RAMP: begin
                    if (stop) begin
                        r_state <= ST_STOP;
                    end else if (r_control == r_target) begin
                        r_state <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (stop) begin
                        r_state <= ST_STOP;
                    end else if (r_target != r_control) begin
                        r_state <= ST_RAMP;
                        r_div   <= '0;
                    end
                end
                ST_STOP: begin
                    if (w_tick && (r_control == '0)) begin
                        r_state  <= ST_IDLE;
                        r_enable <= 1'b0;
                        r_div    <= '0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign set_ready   = ~rst & (r_state != ST_STOP);
    assign control     = r_control;
    assign enable      = r_enable;
    assign period_tick = w_tick;
    assign at_target   = (r_state == ST_HOLD);

endmodule
`default_nettype wire

// File: tb/tb_pwm_ramp_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_pwm_ramp_ctrl
// Description : Self-checking bench for pwm_ramp_ctrl. Four instances with
//               different RAMP_DIV/STEP share stimulus; a behavioural model
//               predicts every output each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_ramp_ctrl;

    localparam int N = 4;
    localparam int P_IDLE = 0, P_ARMED = 1, P_RAMP = 2, P_HOLD = 3, P_STOP = 4;

    logic                clk;
    logic                rst;
    logic                start;
    logic                stop;
    logic                set_valid;
    logic [4:0]          set_duty;
    logic [N-1:0]        rdy;
    logic [N-1:0]        en;
    logic [N-1:0]        at;
    logic [N-1:0]        tk;
    logic [N-1:0][4:0]   ctl;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int ph;
        int ctl;
        int tgt;
        int ticks;
        bit en;
    } mdl_t;

    mdl_t m[N];
    int   mcnt;

    typedef struct {
        bit st; bit sp; bit sv; int sd; int ncyc;
        int e_ctl; bit e_en; bit e_at; bit e_tk; bit e_rdy;
    } vec_t;

    pwm_ramp_ctrl #(.RAMP_DIV(4), .STEP(1)) u_dut0 (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .set_valid(set_valid),
        .set_duty(set_duty), .set_ready(rdy[0]), .control(ctl[0]), .enable(en[0]),
        .period_tick(tk[0]), .at_target(at[0]));
    pwm_ramp_ctrl #(.RAMP_DIV(2), .STEP(3)) u_dut1 (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .set_valid(set_valid),
        .set_duty(set_duty), .set_ready(rdy[1]), .control(ctl[1]), .enable(en[1]),
        .period_tick(tk[1]), .at_target(at[1]));
    pwm_ramp_ctrl #(.RAMP_DIV(1), .STEP(2)) u_dut2 (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .set_valid(set_valid),
        .set_duty(set_duty), .set_ready(rdy[2]), .control(ctl[2]), .enable(en[2]),
        .period_tick(tk[2]), .at_target(at[2]));
    pwm_ramp_ctrl #(.RAMP_DIV(1), .STEP(31)) u_dut3 (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .set_valid(set_valid),
        .set_duty(set_duty), .set_ready(rdy[3]), .control(ctl[3]), .enable(en[3]),
        .period_tick(tk[3]), .at_target(at[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int div_of(int i);
        case (i)
            0: return 4;
            1: return 2;
            default: return 1;
        endcase
    endfunction

    function automatic int step_of(int i);
        case (i)
            0: return 1;
            1: return 3;
            2: return 2;
            default: return 31;
        endcase
    endfunction

    function automatic int toward(int c, int t, int s);
        int d;
        d = (t > c) ? t - c : c - t;
        if (d > s) d = s;
        return (t > c) ? c + d : c - d;
    endfunction

    function automatic void mdl_reset();
        for (int i = 0; i < N; i++) begin
            m[i].ph = P_IDLE; m[i].ctl = 0; m[i].tgt = 0; m[i].ticks = 0; m[i].en = 1'b0;
        end
        mcnt = 0;
    endfunction

    // One rising edge of the behavioural model, using the inputs seen at it.
    function automatic void model_step(int i, bit tick);
        mdl_t n;
        n = m[i];
        if (set_valid && m[i].ph != P_STOP) n.tgt = stop ? 0 : int'(set_duty);
        if (stop && (m[i].ph == P_RAMP || m[i].ph == P_HOLD)) n.tgt = 0;
        case (m[i].ph)
            P_IDLE:  if (start && !stop) n.ph = P_ARMED;
            P_ARMED: begin
                if (stop) n.ph = P_IDLE;
                else if (tick) begin n.ph = P_RAMP; n.en = 1'b1; n.ticks = 0; end
            end
            P_HOLD: begin
                if (stop) n.ph = P_STOP;
                else if (m[i].tgt != m[i].ctl) begin n.ph = P_RAMP; n.ticks = 0; end
            end
            default: begin
                if (tick) begin
                    n.ticks = m[i].ticks + 1;
                    if (n.ticks == div_of(i)) begin
                        n.ctl   = toward(m[i].ctl, m[i].tgt, step_of(i));
                        n.ticks = 0;
                    end
                end
                if (m[i].ph == P_RAMP) begin
                    if (stop) n.ph = P_STOP;
                    else if (m[i].ctl == m[i].tgt) n.ph = P_HOLD;
                end else if (tick && m[i].ctl == 0) begin
                    n.ph = P_IDLE; n.en = 1'b0; n.ticks = 0;
                end
            end
        endcase
        m[i] = n;
    endfunction

    task automatic chk(string nm, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_seq(string nm, input int got[$], input int exp[$]);
        chk({nm, "_len"}, got.size(), exp.size());
        for (int k = 0; k < exp.size() && k < got.size(); k++)
            chk($sformatf("%s[%0d]", nm, k), got[k], exp[k]);
    endtask

    // Outputs packed as {control, enable, at_target, period_tick, set_ready}.
    task automatic check_all();
        for (int i = 0; i < N; i++) begin
            logic [8:0] a;
            logic [8:0] e;
            a = {ctl[i], en[i], at[i], tk[i], rdy[i]};
            e = {5'(m[i].ctl), m[i].en, (m[i].ph == P_HOLD), (!rst && mcnt == 31),
                 (!rst && m[i].ph != P_STOP)};
            chk($sformatf("model%0d", i), int'(a), int'(e));
        end
    endtask

    task automatic cycle();
        bit tick;
        @(posedge clk);
        if (!rst) begin
            tick = (mcnt == 31);
            for (int i = 0; i < N; i++) model_step(i, tick);
            mcnt = (mcnt + 1) % 32;
        end
        #1;
        check_all();
    endtask

    task automatic drive(bit st, bit sp, bit sv, int sd);
        start = st; stop = sp; set_valid = sv; set_duty = 5'(sd);
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0);
        rst = 1'b1;
        mdl_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        rst = 1'b0;
    endtask

    task automatic pulse(bit st, bit sp, bit sv, int sd);
        drive(st, sp, sv, sd);
        cycle();
        drive(0, 0, 0, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[8];
        int   q[$];
        int   e[$];
        int   ok, p, ptk, bad_rdy, fell, fall_ok, first;

        rst = 1'b1;
        drive(0, 0, 0, 0);
        mdl_reset();

        // Soft-start on instance 0: checkpoints counted in edges after reset.
        vt[0] = '{0, 0, 1, 8, 1,   0, 0, 0, 0, 1};
        vt[1] = '{1, 0, 0, 0, 30,  0, 0, 0, 1, 1};
        vt[2] = '{0, 0, 0, 0, 1,   0, 1, 0, 0, 1};
        vt[3] = '{0, 0, 0, 0, 127, 0, 1, 0, 1, 1};
        vt[4] = '{0, 0, 0, 0, 1,   1, 1, 0, 0, 1};
        vt[5] = '{0, 0, 0, 0, 128, 2, 1, 0, 0, 1};
        vt[6] = '{0, 0, 0, 0, 768, 8, 1, 0, 0, 1};
        vt[7] = '{0, 0, 0, 0, 1,   8, 1, 1, 0, 1};
        do_reset();
        for (int r = 0; r < 8; r++) begin
            pulse(vt[r].st, vt[r].sp, vt[r].sv, vt[r].sd);
            repeat (vt[r].ncyc - 1) cycle();
            chk($sformatf("t1_row%0d", r),
                int'({ctl[0], en[0], at[0], tk[0], rdy[0]}),
                int'({5'(vt[r].e_ctl), vt[r].e_en, vt[r].e_at, vt[r].e_tk, vt[r].e_rdy}));
        end

        // Large step on instance 1: 0 -> 7 with STEP 3.
        do_reset();
        pulse(0, 0, 1, 7);
        pulse(1, 0, 0, 0);
        q.delete(); ok = 0;
        for (int k = 0; k < 2000; k++) begin
            p = ctl[1];
            cycle();
            if (ctl[1] != 5'(p)) q.push_back(int'(ctl[1]));
            if (at[1]) begin ok = 1; break; end
        end
        chk("t2_hold", ok, 1);
        e = '{3, 6, 7};
        chk_seq("t2_seq", q, e);

        // Stop from HOLD at 5 on instance 2 (STEP 2).
        do_reset();
        pulse(0, 0, 1, 5);
        pulse(1, 0, 0, 0);
        ok = 0;
        for (int k = 0; k < 1000; k++) begin
            cycle();
            if (at[2]) begin ok = 1; break; end
        end
        chk("t3_hold", ok, 1);
        chk("t3_ctl5", int'(ctl[2]), 5);
        pulse(0, 1, 0, 0);
        q.delete(); bad_rdy = 0; fell = 0; fall_ok = 0;
        if (rdy[2]) bad_rdy++;
        for (int k = 0; k < 500; k++) begin
            p = ctl[2]; ptk = tk[2];
            cycle();
            if (ctl[2] != 5'(p)) q.push_back(int'(ctl[2]));
            if (!en[2]) begin fell = 1; fall_ok = (ptk == 1 && p == 0) ? 1 : 0; break; end
            if (rdy[2]) bad_rdy++;
        end
        chk("t3_fell", fell, 1);
        chk("t3_fall_at_tick0", fall_ok, 1);
        chk("t3_ready_low", bad_rdy, 0);
        e = '{3, 1, 0};
        chk_seq("t3_seq", q, e);
        chk("t3_idle_ready", int'(rdy[2]), 1);

        // Retarget mid-ramp on instance 0: 0 -> 20, then 4 at control 10.
        do_reset();
        pulse(0, 0, 1, 20);
        pulse(1, 0, 0, 0);
        ok = 0;
        for (int k = 0; k < 2000; k++) begin
            cycle();
            if (ctl[0] == 5'd10) begin ok = 1; break; end
        end
        chk("t4_reach10", ok, 1);
        pulse(0, 0, 1, 4);
        q.delete(); ok = 0;
        for (int k = 0; k < 1200; k++) begin
            p = ctl[0];
            cycle();
            if (ctl[0] != 5'(p)) q.push_back(int'(ctl[0]));
            if (at[0]) begin ok = 1; break; end
        end
        chk("t4_hold", ok, 1);
        e = '{9, 8, 7, 6, 5, 4};
        chk_seq("t4_seq", q, e);

        // Start and stop together: stays idle past a period tick.
        do_reset();
        pulse(1, 1, 0, 0);
        repeat (40) cycle();
        chk("t5_idle_en", int'(en[0]), 0);
        // Setpoint offered with stop is discarded: ramp holds at 0.
        pulse(0, 1, 1, 9);
        pulse(1, 0, 0, 0);
        repeat (100) cycle();
        chk("t5_discard", int'({ctl[3], at[3], en[3]}), int'({5'd0, 1'b1, 1'b1}));
        // Full-scale jump with STEP 31 on instance 3.
        do_reset();
        pulse(0, 0, 1, 31);
        pulse(1, 0, 0, 0);
        q.delete(); ok = 0;
        for (int k = 0; k < 200; k++) begin
            p = ctl[3];
            cycle();
            if (ctl[3] != 5'(p)) q.push_back(int'(ctl[3]));
            if (at[3]) begin ok = 1; break; end
        end
        chk("t5_hold31", ok, 1);
        e = '{31};
        chk_seq("t5_seq31", q, e);

        // Reset mid-ramp at control 6: outputs drop without a clock edge.
        do_reset();
        pulse(0, 0, 1, 20);
        pulse(1, 0, 0, 0);
        ok = 0;
        for (int k = 0; k < 1200; k++) begin
            cycle();
            if (ctl[0] == 5'd6) begin ok = 1; break; end
        end
        chk("t6_reach6", ok, 1);
        #3;
        rst = 1'b1;
        mdl_reset();
        #1;
        chk("t6_async_drop", int'({ctl[0], en[0]}), 0);
        check_all();
        #2;
        rst = 1'b0;
        first = -1;
        for (int k = 1; k <= 40; k++) begin
            cycle();
            if (tk[0] && first < 0) first = k;
        end
        chk("t6_first_tick_edge", first, 31);

        // Randomised traffic against the model, with occasional resets.
        do_reset();
        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(0, 999) < 2) begin
                rst = 1'b1;
                mdl_reset();
                cycle();
                rst = 1'b0;
            end else begin
                drive($urandom_range(0, 7) == 0, $urandom_range(0, 399) == 0,
                      $urandom_range(0, 3) == 0, int'($urandom_range(0, 31)));
                cycle();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pwm_ramp_ctrl.md
PWM_RAMP_CTRL -- requirements
Module: pwm_ramp_ctrl

Interface
REQ-001 SHALL have parameter RAMP_DIV, default 4, PWM periods per ramp step (legal 1..255).
REQ-002 SHALL have parameter STEP, default 1, max duty change per step (legal 1..31).
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  request to begin driving the PWM stage (level, sampled per cycle).
REQ-006 SHALL have port stop  input  1  request to ramp down to 0 and disable.
REQ-007 SHALL have port set_valid  input  1  duty setpoint offered.
REQ-008 SHALL have port set_duty  input  5  target duty code 0..31.
REQ-009 SHALL have port set_ready  output  1  setpoint can be accepted this cycle.
REQ-010 SHALL have port control  output  5  duty code driven to the downstream PWM stage.
REQ-011 SHALL have port enable  output  1  enable driven to the downstream PWM stage.
REQ-012 SHALL have port period_tick  output  1  high on the last cycle of each 32-cycle PWM period.
REQ-013 SHALL have port at_target  output  1  high when state is HOLD.

Function
REQ-014 SHALL run a free-running 5-bit period counter 0..31, wrapping 31->0; period_tick = (count == 31).
REQ-015 SHALL change control and enable only on a cycle where period_tick = 1, so each downstream period sees a constant code.
REQ-016 SHALL implement states IDLE, ARMED, RAMP, HOLD, STOP.
REQ-017 IDLE: enable = 0, control = 0; start = 1 and stop = 0 -> ARMED.
REQ-018 ARMED: on period_tick -> RAMP, enable becomes 1, control stays 0; stop = 1 -> IDLE immediately.
REQ-019 RAMP: divider counter counts period_ticks; on the RAMP_DIV-th tick since entering RAMP or since the previous step, control moves toward target by min(STEP, |target - control|) and the divider clears.
REQ-020 Ramp step SHALL never overshoot target and SHALL be computed at 6 bits so control stays within 0..31.
REQ-021 RAMP -> HOLD on the cycle after control equals target; HOLD -> RAMP, divider cleared, on the cycle after target differs from control.
REQ-022 stop = 1 in RAMP or HOLD -> STOP: target forced to 0, ramping continues downward under REQ-019.
REQ-023 STOP: on a period_tick with control == 0, enable becomes 0 -> IDLE.
REQ-024 set_ready = 1 in IDLE, ARMED, RAMP, HOLD; 0 in STOP and during reset.
REQ-025 On set_valid & set_ready the target register SHALL load set_duty at the next edge; mid-ramp target changes take effect at the next step.
REQ-026 Simultaneous start and stop: stop wins. A setpoint accepted in the same cycle as stop SHALL complete its handshake, but its value SHALL be discarded (target = 0).
REQ-027 start while in ARMED/RAMP/HOLD/STOP SHALL be ignored.

Reset
REQ-028 While rst = 1: state IDLE, period counter 0, divider 0, target 0, control 0, enable 0, set_ready 0, period_tick 0, at_target 0.
REQ-029 Reset asserted mid-ramp SHALL drop enable and control to 0 asynchronously, without waiting for a period boundary.
REQ-030 After rst deasserts, the period counter SHALL start at 0 on the first edge.

Structure
REQ-031 Shared package pwm_pkg SHALL hold the state enum, DUTY_W = 5 and PERIOD_LEN = 32.
REQ-032 Period counter and period_tick generation SHALL be sub-module pwm_period_timer; the FSM, divider and target logic stay in pwm_ramp_ctrl.

Verification
REQ-033 Test 1, soft-start: RAMP_DIV = 4, STEP = 1, set_duty = 8, then start. Required: enable rises at the first period_tick; control steps 1..8, one step per 128 cycles; at_target after the eighth step (1024 cycles after arming).
REQ-034 Test 2, large step: STEP = 3, target 0 -> 7. Required: control sequence 3, 6, 7 with no overshoot; then HOLD.
REQ-035 Test 3, stop from HOLD at control = 5 with STEP = 2. Required: control 3, 1, 0 at step boundaries; set_ready = 0 throughout; enable falls at the period_tick with control == 0; state returns to IDLE.
REQ-036 Test 4, retarget mid-ramp: ramping 0 -> 20, new target 4 accepted at control = 10. Required: control decreases 9..4 and the FSM reaches HOLD.
REQ-037 Test 5, boundary cases: start and stop in the same cycle -> remains IDLE; setpoint 31 reached with STEP = 31 -> control saturates at 31.
REQ-038 Test 6, reset mid-ramp: rst pulsed at control = 6. Required: control = 0 and enable = 0 without waiting for a clock edge; the period counter restarts at 0.
